// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects results from three producers (ALU, branch unit, load side of the
//   load/store buffer), buffers each in a small FIFO and drives one registered
//   common-data-bus broadcast per cycle, chosen round-robin over the non-empty
//   FIFO heads. A misprediction from the ROB flushes every pending result.
//
//   Optional build macro CDB_LSB_PRIO_EN:
//     defined   - loads win whenever their FIFO is non-empty; ALU and BRU share
//                 the remaining slots round-robin (rr only moves on ALU/BRU grants)
//     undefined - plain three-way round-robin ALU -> BRU -> LSB -> ALU
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   en                       global enable, low freezes every register
//   iMp                      misprediction flush
//   iALU_En/Qd/Vd            ALU push, tag, value;           oALU_Full
//   iBRU_En/Qd/Vd/Jt         BRU push, tag, link, target;     oBRU_Full
//   iLSB_En/Qd/Vd            load push, tag, data;            oLSB_Full
//   oCDB_En/Qd/Vd/Jt         registered broadcast (Jt is 0 for ALU/LSB entries)

module cdb_arbiter #(
  parameter int BUF_D     = 2,
  parameter int BUF_AW    = 1,
  parameter int ROB_ADD_W = 5,
  parameter int REG_DAT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iMp,
  input  logic                 iALU_En,
  input  logic [ROB_ADD_W-1:0] iALU_Qd,
  input  logic [REG_DAT_W-1:0] iALU_Vd,
  output logic                 oALU_Full,
  input  logic                 iBRU_En,
  input  logic [ROB_ADD_W-1:0] iBRU_Qd,
  input  logic [REG_DAT_W-1:0] iBRU_Vd,
  input  logic [REG_DAT_W-1:0] iBRU_Jt,
  output logic                 oBRU_Full,
  input  logic                 iLSB_En,
  input  logic [ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [REG_DAT_W-1:0] iLSB_Vd,
  output logic                 oLSB_Full,
  output logic                 oCDB_En,
  output logic [ROB_ADD_W-1:0] oCDB_Qd,
  output logic [REG_DAT_W-1:0] oCDB_Vd,
  output logic [REG_DAT_W-1:0] oCDB_Jt
);

  // Source index: 0 = ALU, 1 = BRU, 2 = LSB
  localparam int NSRC = 3;
  localparam logic [BUF_AW:0]   CNT_FULL = (BUF_AW+1)'(BUF_D);
  localparam logic [BUF_AW:0]   CNT_ONE  = (BUF_AW+1)'(1);
  localparam logic [BUF_AW-1:0] PTR_ONE  = BUF_AW'(1);

  logic [NSRC-1:0]      push_req;
  logic [ROB_ADD_W-1:0] push_qd [NSRC];
  logic [REG_DAT_W-1:0] push_vd [NSRC];

  logic [ROB_ADD_W-1:0] qd_mem [NSRC][BUF_D];
  logic [REG_DAT_W-1:0] vd_mem [NSRC][BUF_D];
  logic [REG_DAT_W-1:0] jt_mem [BUF_D];

  logic [BUF_AW-1:0] head [NSRC];
  logic [BUF_AW-1:0] tail [NSRC];
  logic [BUF_AW:0]   cnt  [NSRC];

  logic [NSRC-1:0] not_empty;
  logic [NSRC-1:0] is_full;
  logic [NSRC-1:0] push_ok;
  logic [NSRC-1:0] pop;

  logic       step;
  logic       flush;
  logic [1:0] rr;
  logic [1:0] rr_next;
  logic       gnt_vld;
  logic [1:0] gnt_src;

  logic [ROB_ADD_W-1:0] sel_qd;
  logic [REG_DAT_W-1:0] sel_vd;
  logic [REG_DAT_W-1:0] sel_jt;

  assign step  = en & ~iMp;
  assign flush = en & iMp;

  assign push_req   = {iLSB_En, iBRU_En, iALU_En};
  assign push_qd[0] = iALU_Qd;
  assign push_qd[1] = iBRU_Qd;
  assign push_qd[2] = iLSB_Qd;
  assign push_vd[0] = iALU_Vd;
  assign push_vd[1] = iBRU_Vd;
  assign push_vd[2] = iLSB_Vd;

  assign oALU_Full = is_full[0];
  assign oBRU_Full = is_full[1];
  assign oLSB_Full = is_full[2];

  // Occupancy flags come straight from the registered counts
  always_comb begin
    not_empty = '0;
    is_full   = '0;
    for (int s = 0; s < NSRC; s++) begin
      not_empty[s] = (cnt[s] != '0);
      is_full[s]   = (cnt[s] == CNT_FULL);
    end
  end

  // Grant selection over the heads that were non-empty at the start of the cycle
  always_comb begin
    gnt_vld = |not_empty;
    gnt_src = 2'd0;
`ifdef CDB_LSB_PRIO_EN
    if (not_empty[2]) begin
      gnt_src = 2'd2;
    end else if (rr == 2'd1) begin
      if (not_empty[1])      gnt_src = 2'd1;
      else if (not_empty[0]) gnt_src = 2'd0;
    end else begin
      if (not_empty[0])      gnt_src = 2'd0;
      else if (not_empty[1]) gnt_src = 2'd1;
    end
`else
    if (rr == 2'd1) begin
      if (not_empty[1])      gnt_src = 2'd1;
      else if (not_empty[2]) gnt_src = 2'd2;
      else if (not_empty[0]) gnt_src = 2'd0;
    end else if (rr == 2'd2) begin
      if (not_empty[2])      gnt_src = 2'd2;
      else if (not_empty[0]) gnt_src = 2'd0;
      else if (not_empty[1]) gnt_src = 2'd1;
    end else begin
      if (not_empty[0])      gnt_src = 2'd0;
      else if (not_empty[1]) gnt_src = 2'd1;
      else if (not_empty[2]) gnt_src = 2'd2;
    end
`endif
  end

  // Round-robin pointer moves to the source after the winner; with load
  // priority the LSB grant leaves the ALU/BRU rotation untouched
  always_comb begin
    rr_next = rr;
    if (gnt_vld) begin
      case (gnt_src)
        2'd0:    rr_next = 2'd1;
        2'd1:    rr_next = 2'd2;
        default: begin
`ifdef CDB_LSB_PRIO_EN
          rr_next = rr;
`else
          rr_next = 2'd0;
`endif
        end
      endcase
    end
  end

  // A push into a full FIFO is only taken when the same FIFO is popped this
  // cycle, so the freed slot absorbs it and the count stays put
  always_comb begin
    pop     = '0;
    push_ok = '0;
    for (int s = 0; s < NSRC; s++) begin
      pop[s]     = step & gnt_vld & (gnt_src == 2'(s));
      push_ok[s] = step & push_req[s] & (~is_full[s] | pop[s]);
    end
  end

  // Head entry of the winning FIFO
  always_comb begin
    sel_qd = '0;
    sel_vd = '0;
    sel_jt = '0;
    case (gnt_src)
      2'd0: begin
        sel_qd = qd_mem[0][head[0]];
        sel_vd = vd_mem[0][head[0]];
      end
      2'd1: begin
        sel_qd = qd_mem[1][head[1]];
        sel_vd = vd_mem[1][head[1]];
        sel_jt = jt_mem[head[1]];
      end
      2'd2: begin
        sel_qd = qd_mem[2][head[2]];
        sel_vd = vd_mem[2][head[2]];
      end
      default: ;
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by the counts alone
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push_ok[s]) begin
        qd_mem[s][tail[s]] <= push_qd[s];
        vd_mem[s][tail[s]] <= push_vd[s];
      end
    end
    if (push_ok[1]) jt_mem[tail[1]] <= iBRU_Jt;
  end

  // Pointers, counts and the round-robin state; a flush drops everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        head[s] <= '0;
        tail[s] <= '0;
        cnt[s]  <= '0;
      end
      rr <= 2'd0;
    end else if (flush) begin
      for (int s = 0; s < NSRC; s++) begin
        head[s] <= '0;
        tail[s] <= '0;
        cnt[s]  <= '0;
      end
      rr <= 2'd0;
    end else if (step) begin
      for (int s = 0; s < NSRC; s++) begin
        if (push_ok[s]) tail[s] <= tail[s] + PTR_ONE;
        if (pop[s])     head[s] <= head[s] + PTR_ONE;
        if (push_ok[s] && !pop[s])      cnt[s] <= cnt[s] + CNT_ONE;
        else if (!push_ok[s] && pop[s]) cnt[s] <= cnt[s] - CNT_ONE;
      end
      rr <= rr_next;
    end
  end

  // Broadcast register; data fields hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oCDB_En <= 1'b0;
      oCDB_Qd <= '0;
      oCDB_Vd <= '0;
      oCDB_Jt <= '0;
    end else if (flush) begin
      oCDB_En <= 1'b0;
    end else if (step) begin
      oCDB_En <= gnt_vld;
      if (gnt_vld) begin
        oCDB_Qd <= sel_qd;
        oCDB_Vd <= sel_vd;
        oCDB_Jt <= sel_jt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter. A queue-based model of the three
//   FIFOs predicts every broadcast (with the cycle it must appear in) into a
//   scoreboard; observed broadcasts are collected alongside and each scenario
//   task drains and compares both, plus its own directed checks.

module tb_cdb_arbiter;

  localparam int QW    = 5;
  localparam int DW    = 32;
  localparam int BUF_D = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          iMp;
  logic          iALU_En;
  logic [QW-1:0] iALU_Qd;
  logic [DW-1:0] iALU_Vd;
  logic          oALU_Full;
  logic          iBRU_En;
  logic [QW-1:0] iBRU_Qd;
  logic [DW-1:0] iBRU_Vd;
  logic [DW-1:0] iBRU_Jt;
  logic          oBRU_Full;
  logic          iLSB_En;
  logic [QW-1:0] iLSB_Qd;
  logic [DW-1:0] iLSB_Vd;
  logic          oLSB_Full;
  logic          oCDB_En;
  logic [QW-1:0] oCDB_Qd;
  logic [DW-1:0] oCDB_Vd;
  logic [DW-1:0] oCDB_Jt;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .BUF_D(BUF_D), .BUF_AW(1), .ROB_ADD_W(QW), .REG_DAT_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .iMp(iMp),
    .iALU_En(iALU_En), .iALU_Qd(iALU_Qd), .iALU_Vd(iALU_Vd), .oALU_Full(oALU_Full),
    .iBRU_En(iBRU_En), .iBRU_Qd(iBRU_Qd), .iBRU_Vd(iBRU_Vd), .iBRU_Jt(iBRU_Jt),
    .oBRU_Full(oBRU_Full),
    .iLSB_En(iLSB_En), .iLSB_Qd(iLSB_Qd), .iLSB_Vd(iLSB_Vd), .oLSB_Full(oLSB_Full),
    .oCDB_En(oCDB_En), .oCDB_Qd(oCDB_Qd), .oCDB_Vd(oCDB_Vd), .oCDB_Jt(oCDB_Jt)
  );

  typedef struct packed {
    logic [QW-1:0] qd;
    logic [DW-1:0] vd;
    logic [DW-1:0] jt;
  } ent_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [QW-1:0] qd;
    logic [DW-1:0] vd;
    logic [DW-1:0] jt;
  } bc_t;

  ent_t m_alu[$];
  ent_t m_bru[$];
  ent_t m_lsb[$];
  int   m_rr;
  bc_t  exp_q[$];
  bc_t  obs_q[$];
  bc_t  eb;
  bc_t  ob;
  int   cyc;
  int   total;
  int   bad;

  // Model of one clock edge, evaluated with the inputs about to be sampled
  task automatic model_step();
    int   pre[3];
    int   g;
    bit   popped[3];
    ent_t e;
    bc_t  b;
    if (rst || !en) return;
    if (iMp) begin
      m_alu.delete(); m_bru.delete(); m_lsb.delete();
      m_rr = 0;
      return;
    end
    pre[0] = m_alu.size(); pre[1] = m_bru.size(); pre[2] = m_lsb.size();
    popped = '{0, 0, 0};
    g = -1;
`ifdef CDB_LSB_PRIO_EN
    if (pre[2] > 0)      g = 2;
    else if (m_rr == 1)  g = (pre[1] > 0) ? 1 : ((pre[0] > 0) ? 0 : -1);
    else                 g = (pre[0] > 0) ? 0 : ((pre[1] > 0) ? 1 : -1);
    if (g == 0 || g == 1) m_rr = g + 1;
`else
    for (int k = 0; k < 3; k++)
      if (g < 0 && pre[(m_rr + k) % 3] > 0) g = (m_rr + k) % 3;
    if (g >= 0) m_rr = (g + 1) % 3;
`endif
    if (g >= 0) begin
      case (g)
        0:       e = m_alu.pop_front();
        1:       e = m_bru.pop_front();
        default: e = m_lsb.pop_front();
      endcase
      popped[g] = 1'b1;
      b.cyc = 32'(cyc + 1); b.qd = e.qd; b.vd = e.vd; b.jt = e.jt;
      exp_q.push_back(b);
    end
    if (iALU_En && (pre[0] < BUF_D || popped[0])) m_alu.push_back('{iALU_Qd, iALU_Vd, {DW{1'b0}}});
    if (iBRU_En && (pre[1] < BUF_D || popped[1])) m_bru.push_back('{iBRU_Qd, iBRU_Vd, iBRU_Jt});
    if (iLSB_En && (pre[2] < BUF_D || popped[2])) m_lsb.push_back('{iLSB_Qd, iLSB_Vd, {DW{1'b0}}});
  endtask

  // Advance one clock; record what the DUT broadcast on an enabled edge
  task automatic tick();
    logic live;
    bc_t  b;
    live = en && !rst;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (live && oCDB_En) begin
      b.cyc = 32'(cyc); b.qd = oCDB_Qd; b.vd = oCDB_Vd; b.jt = oCDB_Jt;
      obs_q.push_back(b);
    end
  endtask

  task automatic idle();
    iALU_En = 1'b0; iBRU_En = 1'b0; iLSB_En = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; iMp = 1'b0; idle();
    iALU_Qd = '0; iALU_Vd = '0; iBRU_Qd = '0; iBRU_Vd = '0; iBRU_Jt = '0;
    iLSB_Qd = '0; iLSB_Vd = '0;
    #12;
    total++;
    if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%b need=0", oCDB_En); end
    total++;
    if (oCDB_Qd !== '0) begin bad++; $display("[TB] FAIL reset_qd got=%0d need=0", oCDB_Qd); end
    total++;
    if (oCDB_Vd !== '0) begin bad++; $display("[TB] FAIL reset_vd got=%h need=0", oCDB_Vd); end
    total++;
    if (oCDB_Jt !== '0) begin bad++; $display("[TB] FAIL reset_jt got=%h need=0", oCDB_Jt); end
    total++;
    if ({oLSB_Full, oBRU_Full, oALU_Full} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_full got=%b need=000", {oLSB_Full, oBRU_Full, oALU_Full});
    end
    rst = 1'b0;
  endtask

  task automatic test_three_way();
    int ord[3];
`ifdef CDB_LSB_PRIO_EN
    ord = '{7, 1, 5};
`else
    ord = '{1, 5, 7};
`endif
    iALU_En = 1'b1; iALU_Qd = 5'd1; iALU_Vd = 32'h11;
    iBRU_En = 1'b1; iBRU_Qd = 5'd5; iBRU_Vd = 32'h55; iBRU_Jt = 32'h100;
    iLSB_En = 1'b1; iLSB_Qd = 5'd7; iLSB_Vd = 32'h77;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (oCDB_En !== 1'b1 || oCDB_Qd !== QW'(ord[k]) || oCDB_Jt !== ((ord[k] == 5) ? 32'h100 : 32'h0)) begin
        bad++;
        $display("[TB] FAIL order%0d got en=%b qd=%0d jt=%h need en=1 qd=%0d", k, oCDB_En, oCDB_Qd, oCDB_Jt, ord[k]);
      end
    end
    tick();
    total++;
    if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL order_idle got=%b need=0", oCDB_En); end
    iALU_En = 1'b1; iALU_Qd = 5'd2; iALU_Vd = 32'h22;
    iBRU_En = 1'b1; iBRU_Qd = 5'd6; iBRU_Vd = 32'h66; iBRU_Jt = 32'h104;
    tick();
    idle();
    tick();
    total++;
    if (oCDB_Qd !== 5'd2) begin bad++; $display("[TB] FAIL rr_restart got=%0d need=2", oCDB_Qd); end
    tick();
    total++;
    if (oCDB_Qd !== 5'd6 || oCDB_Jt !== 32'h104) begin
      bad++; $display("[TB] FAIL rr_second got qd=%0d jt=%h need qd=6 jt=104", oCDB_Qd, oCDB_Jt);
    end
    tick();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL three_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL three_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  task automatic test_single_alu();
    iALU_En = 1'b1; iALU_Qd = 5'd3; iALU_Vd = 32'h2A;
    tick();
    idle();
    tick();
    total++;
    if (oCDB_En !== 1'b1 || oCDB_Qd !== 5'd3 || oCDB_Vd !== 32'h2A || oCDB_Jt !== 32'h0) begin
      bad++;
      $display("[TB] FAIL single_alu got en=%b qd=%0d vd=%h jt=%h need en=1 qd=3 vd=2a jt=0",
               oCDB_En, oCDB_Qd, oCDB_Vd, oCDB_Jt);
    end
    tick();
    total++;
    if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL single_alu_off got=%b need=0", oCDB_En); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL single_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL single_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  task automatic test_alu_full();
    bit seen23;
    for (int k = 0; k < 6; k++) begin
      iALU_En = (k < 4); iALU_Qd = QW'(20 + k); iALU_Vd = 32'h200 + k;
      iLSB_En = 1'b1;    iLSB_Qd = QW'(8 + k);  iLSB_Vd = 32'h300 + k;
      tick();
      total++;
      if (oALU_Full !== (m_alu.size() == BUF_D) || oLSB_Full !== (m_lsb.size() == BUF_D)) begin
        bad++;
        $display("[TB] FAIL full_track%0d got alu=%b lsb=%b need alu=%b lsb=%b", k, oALU_Full, oLSB_Full,
                 m_alu.size() == BUF_D, m_lsb.size() == BUF_D);
      end
      if (k == 1 || k == 3) begin
        total++;
        if (oALU_Full !== 1'b1) begin bad++; $display("[TB] FAIL alu_full%0d got=%b need=1", k, oALU_Full); end
      end
    end
    idle();
    repeat (8) tick();
    seen23 = 1'b0;
    foreach (obs_q[i]) if (obs_q[i].qd == 5'd23) seen23 = 1'b1;
    total++;
    if (seen23) begin bad++; $display("[TB] FAIL dropped_push got tag23=1 need tag23=0"); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL full_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL full_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 6; k++) begin
      if (m_alu.size() == BUF_D && m_bru.size() == BUF_D && m_lsb.size() == BUF_D) break;
      iALU_En = 1'b1; iALU_Qd = QW'(16 + k); iALU_Vd = 32'h400 + k;
      iBRU_En = 1'b1; iBRU_Qd = QW'(24 + k); iBRU_Vd = 32'h500 + k; iBRU_Jt = 32'h1000 + k;
      iLSB_En = 1'b1; iLSB_Qd = QW'(8 + k);  iLSB_Vd = 32'h600 + k;
      tick();
    end
    total++;
    if ({oLSB_Full, oBRU_Full, oALU_Full} !== 3'b111) begin
      bad++; $display("[TB] FAIL flush_prefill got=%b need=111", {oLSB_Full, oBRU_Full, oALU_Full});
    end
    idle();
    iMp = 1'b1; iBRU_En = 1'b1; iBRU_Qd = 5'd30; iBRU_Vd = 32'h30; iBRU_Jt = 32'h300;
    tick();
    iMp = 1'b0; idle();
    total++;
    if ({oLSB_Full, oBRU_Full, oALU_Full} !== 3'b000 || oCDB_En !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush got full=%b en=%b need full=000 en=0", {oLSB_Full, oBRU_Full, oALU_Full}, oCDB_En);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL flush_quiet%0d got=%b need=0", k, oCDB_En); end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL flush_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL flush_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    iALU_En = 1'b1; iALU_Qd = 5'd4; iALU_Vd = 32'h44;
    iBRU_En = 1'b1; iBRU_Qd = 5'd9; iBRU_Vd = 32'h99; iBRU_Jt = 32'h180;
    tick();
    idle();
    tick();
    total++;
    if (oCDB_En !== 1'b1 || oCDB_Qd !== 5'd4) begin
      bad++; $display("[TB] FAIL hold_pre got en=%b qd=%0d need en=1 qd=4", oCDB_En, oCDB_Qd);
    end
    en = 1'b0;
    iLSB_En = 1'b1; iLSB_Qd = 5'd12; iLSB_Vd = 32'hCC;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (oCDB_En !== 1'b1 || oCDB_Qd !== 5'd4 || oCDB_Vd !== 32'h44) begin
        bad++;
        $display("[TB] FAIL hold%0d got en=%b qd=%0d vd=%h need en=1 qd=4 vd=44", k, oCDB_En, oCDB_Qd, oCDB_Vd);
      end
    end
    en = 1'b1;
    idle();
    tick();
    total++;
    if (oCDB_En !== 1'b1 || oCDB_Qd !== 5'd9 || oCDB_Jt !== 32'h180) begin
      bad++;
      $display("[TB] FAIL hold_resume got en=%b qd=%0d jt=%h need en=1 qd=9 jt=180", oCDB_En, oCDB_Qd, oCDB_Jt);
    end
    tick();
    total++;
    if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL hold_ignored_push got=%b need=0", oCDB_En); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL hold_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL hold_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    iALU_En = 1'b1; iALU_Qd = 5'd13; iALU_Vd = 32'h13;
    iBRU_En = 1'b1; iBRU_Qd = 5'd14; iBRU_Vd = 32'h14; iBRU_Jt = 32'h140;
    iLSB_En = 1'b1; iLSB_Qd = 5'd15; iLSB_Vd = 32'h15;
    tick();
    idle();
    tick();
    total++;
    if (oCDB_En !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre got=%b need=1", oCDB_En); end
    #3;
    rst = 1'b1;
    m_alu.delete(); m_bru.delete(); m_lsb.delete();
    m_rr = 0;
    #1;
    total++;
    if (oCDB_En !== 1'b0 || oCDB_Qd !== '0) begin
      bad++; $display("[TB] FAIL areset_now got en=%b qd=%0d need en=0 qd=0", oCDB_En, oCDB_Qd);
    end
    #1;
    rst = 1'b0;
    total++;
    if ({oLSB_Full, oBRU_Full, oALU_Full} !== 3'b000) begin
      bad++; $display("[TB] FAIL areset_full got=%b need=000", {oLSB_Full, oBRU_Full, oALU_Full});
    end
    iALU_En = 1'b1; iALU_Qd = 5'd17; iALU_Vd = 32'h1717;
    tick();
    idle();
    tick();
    total++;
    if (oCDB_En !== 1'b1 || oCDB_Qd !== 5'd17 || oCDB_Vd !== 32'h1717) begin
      bad++;
      $display("[TB] FAIL areset_first got en=%b qd=%0d vd=%h need en=1 qd=17 vd=1717", oCDB_En, oCDB_Qd, oCDB_Vd);
    end
    tick();
    total++;
    if (oCDB_En !== 1'b0) begin bad++; $display("[TB] FAIL areset_after got=%b need=0", oCDB_En); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      total++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL areset_sb count got_left=%0d need_left=%0d", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        eb = exp_q.pop_front(); ob = obs_q.pop_front();
        if (ob !== eb) begin
          bad++;
          $display("[TB] FAIL areset_sb got cyc=%0d qd=%0d vd=%h jt=%h need cyc=%0d qd=%0d vd=%h jt=%h",
                   ob.cyc, ob.qd, ob.vd, ob.jt, eb.cyc, eb.qd, eb.vd, eb.jt);
        end
      end
    end
  endtask

  // Scenario sequence; rr is 0 out of reset for the three-way ordering check
  initial begin
    total = 0; bad = 0; cyc = 0; m_rr = 0;
    test_reset();
    test_three_way();
    test_single_alu();
    test_alu_full();
    test_flush();
    test_enable_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running need=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single result broadcast bus (CDB) into the ROB result port and the RS/LSB wakeup logic.
- Three producers feed it: ALU, branch/jump unit (BRU) and load/store buffer (LSB loads). Each producer has a small FIFO.
- Selects one head per cycle, round-robin, and drives a registered CDB. Misprediction from the ROB flushes all pending results.

Parameters:
- BUF_D, 2, entries per producer FIFO (power of two, >=2)
- BUF_AW, 1, log2(BUF_D)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes all state
- iMp  in  1  misprediction flush from ROB
- iALU_En  in  1  ALU result push
- iALU_Qd  in  ROB_ADD_W  ALU destination ROB tag
- iALU_Vd  in  REG_DAT_W  ALU result
- oALU_Full  out  1  ALU FIFO full
- iBRU_En  in  1  BRU result push
- iBRU_Qd  in  ROB_ADD_W  BRU tag
- iBRU_Vd  in  REG_DAT_W  link value (rd result)
- iBRU_Jt  in  REG_DAT_W  resolved jump target
- oBRU_Full  out  1  BRU FIFO full
- iLSB_En  in  1  load result push
- iLSB_Qd  in  ROB_ADD_W  load tag
- iLSB_Vd  in  REG_DAT_W  load data
- oLSB_Full  out  1  LSB FIFO full
- oCDB_En  out  1  broadcast valid
- oCDB_Qd  out  ROB_ADD_W  broadcast tag
- oCDB_Vd  out  REG_DAT_W  broadcast value
- oCDB_Jt  out  REG_DAT_W  broadcast jump target (0 for ALU/LSB entries)

Behaviour:
- Reset (async, rst=1): all FIFOs empty, all pointers and counts 0, rr=0. oCDB_En/Qd/Vd/Jt=0. All Full outputs 0.
- FIFO layout: per producer, head/tail of BUF_AW bits wrapping modulo BUF_D; count of BUF_AW+1 bits. Full = (count==BUF_D), registered, derived from count.
- Push: on a posedge with en=1 and iMp=0, XX_En=1 writes {Qd,Vd,Jt} at tail. Producers must not push while Full. A push while Full is dropped; FIFO contents are unchanged.
- Simultaneous push and pop on one FIFO is legal, including when full: count unchanged, Full stays as is.
- Grant: combinational over FIFO heads that are non-empty at the start of the cycle. Round-robin order starts at rr (0=ALU, 1=BRU, 2=LSB) and wraps 2->0. After a grant to source s, rr <= (s+1) mod 3. With no request, rr holds.
- Output register: on a posedge with en=1 and iMp=0, the granted head is popped and loaded into oCDB_*, with oCDB_En=1. With no grant, oCDB_En=0 and other outputs hold.
- Latency: an entry pushed at edge k is broadcast no earlier than after edge k+1. There is no same-cycle bypass.
- Flush: iMp=1 at an edge with en=1 empties all FIFOs, sets oCDB_En=0 and rr=0, drops same-cycle pushes, and clears Full.
- en=0: every register holds, including oCDB_*. Pushes are ignored. The ROB samples the held broadcast once en returns.
- Tag 0 is never pushed; it is reserved as "no tag" by the ROB. A push with Qd=0 is accepted and broadcast unchanged.

Optional Feature:
- Macro CDB_LSB_PRIO_EN.
- Defined: LSB has fixed highest priority whenever its FIFO is non-empty. ALU/BRU round-robin between themselves using rr, which is updated only on ALU/BRU grants.
- Undefined: plain 3-way round-robin as above.

Test Plan:
- Single ALU push (Qd=3, Vd=0x2A) at edge 1, nothing else -> oCDB_En=1, Qd=3, Vd=0x2A, Jt=0 after edge 2; oCDB_En=0 after edge 3.
- ALU, BRU (Qd=5, Jt=0x100) and LSB (Qd=7) push together from rr=0 -> broadcast order ALU, BRU, LSB on three consecutive cycles; rr=0 afterwards. With CDB_LSB_PRIO_EN: order LSB, ALU, BRU.
- Four ALU pushes on consecutive cycles, BUF_D=2, competing with continuous LSB traffic -> oALU_Full asserts. The push made while full is dropped, and no tag is lost among the accepted ones.
- Two entries in each FIFO, iMp=1 for one cycle together with a BRU push -> all Full outputs 0 and oCDB_En=0 next cycle; no further broadcasts.
- en held low for 3 cycles while oCDB_En=1, Qd=4 -> outputs stable for all 3 cycles; after en returns, the next pending entry follows.
- rst asserted asynchronously mid-cycle with FIFOs non-empty -> oCDB_En drops immediately without waiting for a clock edge; after release, Full outputs are 0 and the first push is broadcast with 1-cycle latency.
